// File: rtl/lsu_mem_responder.sv
// -----------------------------------------------------------------------------
// lsu_mem_responder
//
// Serves load/store requests from an accelerator LSU and turns each accepted
// request into a single access on a word-wide SRAM-style port that uses a
// req/gnt/rvalid handshake. It forms the address (base + offset), steers
// byte/halfword data onto the correct lanes, rejects misaligned or malformed
// requests without touching memory, and aborts reads whose data never arrives.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   lsu_ren/lsu_wen   level read/write request, sampled only in IDLE
//   lsu_type          00 byte, 01 halfword, 10 word, 11 invalid
//   lsu_addr_base     base byte address
//   lsu_addr_offset   byte offset added to the base (wraps modulo 2^32)
//   lsu_wdata         right-aligned store data
//   lsu_done          one-cycle completion pulse
//   lsu_err           error flag, meaningful only while lsu_done is high
//   lsu_rdata         zero-extended load data, held until the next good load
//   busy              high whenever the responder is not idle
//   mem_req           memory request, held until mem_gnt
//   mem_we            1 = write access
//   mem_addr          word address (bits [1:0] are always 0)
//   mem_be            byte enables
//   mem_wdata         store data replicated across all lanes
//   mem_gnt           request accepted in this cycle
//   mem_rvalid        read data valid (earliest the cycle after mem_gnt)
//   mem_rdata         read data
// -----------------------------------------------------------------------------
module lsu_mem_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_ren,
    input  logic        lsu_wen,
    input  logic [1:0]  lsu_type,
    input  logic [31:0] lsu_addr_base,
    input  logic [31:0] lsu_addr_offset,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] lsu_rdata,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // Wide enough to hold TIMEOUT_CYCLES itself.
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT_R = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [1:0]         addr_lo_q,   addr_lo_d;
    logic [1:0]         type_q,      type_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               done_q,      done_d;
    logic               err_q,       err_d;
    logic [31:0]        rdata_q,     rdata_d;
    logic               busy_q,      busy_d;
    logic               mem_req_q,   mem_req_d;
    logic               mem_we_q,    mem_we_d;
    logic [31:0]        mem_addr_q,  mem_addr_d;
    logic [3:0]         mem_be_q,    mem_be_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    // Request decode, evaluated on the live inputs during the IDLE cycle.
    logic [31:0]      addr_sum;
    logic             req_err;
    logic [3:0]       be_calc;
    logic [31:0]      wdata_calc;
    // Load data extraction, based on the latched address/type.
    logic [31:0]      rd_shift;
    logic [31:0]      rd_ext;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        addr_sum = lsu_addr_base + lsu_addr_offset;

        req_err = (lsu_ren & lsu_wen)
                | (lsu_type == 2'b11)
                | ((lsu_type == 2'b01) & addr_sum[0])
                | ((lsu_type == 2'b10) & (addr_sum[1:0] != 2'b00));

        case (lsu_type)
            2'b00:   be_calc = 4'b0001 << addr_sum[1:0];
            2'b01:   be_calc = 4'b0011 << addr_sum[1:0];
            default: be_calc = 4'b1111;
        endcase

        // Replicating the store data means the addressed lanes always carry
        // the right bytes, whatever the offset within the word.
        case (lsu_type)
            2'b00:   wdata_calc = {4{lsu_wdata[7:0]}};
            2'b01:   wdata_calc = {2{lsu_wdata[15:0]}};
            default: wdata_calc = lsu_wdata;
        endcase

        rd_shift = mem_rdata >> {addr_lo_q, 3'b000};
        case (type_q)
            2'b00:   rd_ext = {24'h0, rd_shift[7:0]};
            2'b01:   rd_ext = {16'h0, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase

        cnt_inc = cnt_q + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (lsu_ren | lsu_wen) begin
                    addr_lo_d   = addr_sum[1:0];
                    type_d      = lsu_type;
                    cnt_d       = '0;
                    mem_we_d    = lsu_wen;
                    mem_addr_d  = {addr_sum[31:2], 2'b00};
                    mem_be_d    = be_calc;
                    mem_wdata_d = wdata_calc;
                    if (req_err) begin
                        // Rejected requests never reach the memory port.
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = S_ISSUE;
                        mem_req_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT_R;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT_R: begin
                // Data arriving in the last allowed cycle still wins over
                // the timeout.
                if (mem_rvalid) begin
                    rdata_d = rd_ext;
                    state_d = S_RESP;
                    done_d  = 1'b1;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d = S_RESP;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_lo_q   <= '0;
            type_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            type_q      <= type_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign lsu_done  = done_q;
    assign lsu_err   = err_q;
    assign lsu_rdata = rdata_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
